// File: rtl/vm_parameter.sv
// Shared vending-machine constants: denomination codes, values, default stock and controller states.
package vm_parameter;

  localparam int unsigned NUM_DENOM = 15;

  localparam logic [3:0] DENOM_CODE_50000 = 4'd1;
  localparam logic [3:0] DENOM_CODE_20000 = 4'd2;
  localparam logic [3:0] DENOM_CODE_10000 = 4'd3;
  localparam logic [3:0] DENOM_CODE_5000  = 4'd4;
  localparam logic [3:0] DENOM_CODE_2000  = 4'd5;
  localparam logic [3:0] DENOM_CODE_1000  = 4'd6;
  localparam logic [3:0] DENOM_CODE_500   = 4'd7;
  localparam logic [3:0] DENOM_CODE_200   = 4'd8;
  localparam logic [3:0] DENOM_CODE_100   = 4'd9;
  localparam logic [3:0] DENOM_CODE_50    = 4'd10;
  localparam logic [3:0] DENOM_CODE_25    = 4'd11;
  localparam logic [3:0] DENOM_CODE_10    = 4'd12;
  localparam logic [3:0] DENOM_CODE_5     = 4'd13;
  localparam logic [3:0] DENOM_CODE_2     = 4'd14;
  localparam logic [3:0] DENOM_CODE_1     = 4'd15;

  // Stock loaded into each counter at reset.
  localparam int unsigned DENOMINATION_AMOUNT_50000 = 100;
  localparam int unsigned DENOMINATION_AMOUNT_20000 = 100;
  localparam int unsigned DENOMINATION_AMOUNT_10000 = 100;
  localparam int unsigned DENOMINATION_AMOUNT_5000  = 100;
  localparam int unsigned DENOMINATION_AMOUNT_2000  = 100;
  localparam int unsigned DENOMINATION_AMOUNT_1000  = 100;
  localparam int unsigned DENOMINATION_AMOUNT_500   = 100;
  localparam int unsigned DENOMINATION_AMOUNT_200   = 100;
  localparam int unsigned DENOMINATION_AMOUNT_100   = 100;
  localparam int unsigned DENOMINATION_AMOUNT_50    = 100;
  localparam int unsigned DENOMINATION_AMOUNT_25    = 100;
  localparam int unsigned DENOMINATION_AMOUNT_10    = 100;
  localparam int unsigned DENOMINATION_AMOUNT_5     = 100;
  localparam int unsigned DENOMINATION_AMOUNT_2     = 100;
  localparam int unsigned DENOMINATION_AMOUNT_1     = 100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAN  = 3'd1,
    EJECT = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } state_e;

  function automatic logic [31:0] denom_value(input logic [3:0] code);
    case (code)
      DENOM_CODE_50000: denom_value = 32'd50000;
      DENOM_CODE_20000: denom_value = 32'd20000;
      DENOM_CODE_10000: denom_value = 32'd10000;
      DENOM_CODE_5000:  denom_value = 32'd5000;
      DENOM_CODE_2000:  denom_value = 32'd2000;
      DENOM_CODE_1000:  denom_value = 32'd1000;
      DENOM_CODE_500:   denom_value = 32'd500;
      DENOM_CODE_200:   denom_value = 32'd200;
      DENOM_CODE_100:   denom_value = 32'd100;
      DENOM_CODE_50:    denom_value = 32'd50;
      DENOM_CODE_25:    denom_value = 32'd25;
      DENOM_CODE_10:    denom_value = 32'd10;
      DENOM_CODE_5:     denom_value = 32'd5;
      DENOM_CODE_2:     denom_value = 32'd2;
      DENOM_CODE_1:     denom_value = 32'd1;
      default:          denom_value = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] denom_default(input logic [3:0] code);
    case (code)
      DENOM_CODE_50000: denom_default = DENOMINATION_AMOUNT_50000;
      DENOM_CODE_20000: denom_default = DENOMINATION_AMOUNT_20000;
      DENOM_CODE_10000: denom_default = DENOMINATION_AMOUNT_10000;
      DENOM_CODE_5000:  denom_default = DENOMINATION_AMOUNT_5000;
      DENOM_CODE_2000:  denom_default = DENOMINATION_AMOUNT_2000;
      DENOM_CODE_1000:  denom_default = DENOMINATION_AMOUNT_1000;
      DENOM_CODE_500:   denom_default = DENOMINATION_AMOUNT_500;
      DENOM_CODE_200:   denom_default = DENOMINATION_AMOUNT_200;
      DENOM_CODE_100:   denom_default = DENOMINATION_AMOUNT_100;
      DENOM_CODE_50:    denom_default = DENOMINATION_AMOUNT_50;
      DENOM_CODE_25:    denom_default = DENOMINATION_AMOUNT_25;
      DENOM_CODE_10:    denom_default = DENOMINATION_AMOUNT_10;
      DENOM_CODE_5:     denom_default = DENOMINATION_AMOUNT_5;
      DENOM_CODE_2:     denom_default = DENOMINATION_AMOUNT_2;
      DENOM_CODE_1:     denom_default = DENOMINATION_AMOUNT_1;
      default:          denom_default = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_inventory.sv
// Per-denomination stock counters with an overwrite (load) port and a single-step decrement port.
module change_inventory
  import vm_parameter::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_en,
  input  logic [3:0]                  load_code,
  input  logic [CNT_W-1:0]            load_count,
  input  logic                        dec_en,
  input  logic [3:0]                  dec_code,
  output logic [15:0][CNT_W-1:0]      inv
);

  logic [15:0][CNT_W-1:0] inv_q, inv_d;

  // Slot 0 is not a valid code and stays at zero.
  always_comb begin
    inv_d = inv_q;
    if (load_en && load_code != 4'd0) begin
      inv_d[load_code] = load_count;
    end else if (dec_en && dec_code != 4'd0) begin
      inv_d[dec_code] = inv_q[dec_code] - 1'b1;
    end
    inv_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        inv_q[i] <= CNT_W'(denom_default(4'(i)));
      end
    end else begin
      inv_q <= inv_d;
    end
  end

  assign inv = inv_q;

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: plans a payout against stock, then ejects one item per handshake.
module change_dispenser
  import vm_parameter::*;
#(
  parameter int AMT_W = 17,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  output logic             eject_valid,
  output logic [3:0]       eject_code,
  input  logic             eject_ready,
  output logic             done,
  output logic             fail,
  output logic             busy,
  input  logic             load_valid,
  input  logic [3:0]       load_code,
  input  logic [CNT_W-1:0] load_count
);

  state_e                 state_q, state_d;
  logic [AMT_W-1:0]       rem_q, rem_d;
  logic [3:0]             idx_q, idx_d;
  logic [15:0][CNT_W-1:0] plan_q, plan_d;
  logic [15:0][CNT_W-1:0] inv;
  logic [AMT_W-1:0]       cur_val;
  logic                   load_en, dec_en;

  change_inventory #(.CNT_W(CNT_W)) u_inv (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_code  (load_code),
    .load_count (load_count),
    .dec_en     (dec_en),
    .dec_code   (idx_q),
    .inv        (inv)
  );

  assign cur_val   = AMT_W'(denom_value(idx_q));
  assign busy      = (state_q != IDLE);
  // Gated by rst_n so ready stays low while reset is held.
  assign req_ready = rst_n && (state_q == IDLE) && !load_valid;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    plan_d      = plan_q;
    eject_valid = 1'b0;
    eject_code  = 4'd0;
    done        = 1'b0;
    fail        = 1'b0;
    load_en     = 1'b0;
    dec_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          load_en = 1'b1;
        end else if (req_valid) begin
          rem_d   = req_amount;
          plan_d  = '0;
          idx_d   = 4'd1;
          state_d = PLAN;
        end
      end
      PLAN: begin
        if (rem_q == '0) begin
          idx_d   = 4'd1;
          state_d = EJECT;
        end else if (rem_q >= cur_val && inv[idx_q] > plan_q[idx_q]) begin
          rem_d          = rem_q - cur_val;
          plan_d[idx_q]  = plan_q[idx_q] + 1'b1;
        end else if (idx_q == 4'd15) begin
          state_d = FAIL;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      EJECT: begin
        // Remaining plan entries are always at or above idx, so idx never wraps.
        if (plan_q == '0) begin
          state_d = DONE;
        end else if (plan_q[idx_q] == '0) begin
          idx_d = idx_q + 4'd1;
        end else begin
          eject_valid = 1'b1;
          eject_code  = idx_q;
          if (eject_ready) begin
            plan_d[idx_q] = plan_q[idx_q] - 1'b1;
            dec_en        = 1'b1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      FAIL: begin
        fail    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      plan_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      plan_q  <= plan_d;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected ejects/done/fail queued by stimulus, popped by a monitor.
module tb_change_dispenser;
  import vm_parameter::*;

  localparam int AMT_W   = 17;
  localparam int CNT_W   = 8;
  localparam int EV_DONE = 16;
  localparam int EV_FAIL = 17;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount;
  logic             eject_valid;
  logic [3:0]       eject_code;
  logic             eject_ready;
  logic             done;
  logic             fail;
  logic             busy;
  logic             load_valid;
  logic [3:0]       load_code;
  logic [CNT_W-1:0] load_count;

  int exp_q[$];
  int exp_inv[16];
  int checks = 0;
  int errors = 0;

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_amount  (req_amount),
    .eject_valid (eject_valid),
    .eject_code  (eject_code),
    .eject_ready (eject_ready),
    .done        (done),
    .fail        (fail),
    .busy        (busy),
    .load_valid  (load_valid),
    .load_code   (load_code),
    .load_count  (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  task automatic pop_check(input string nm, input int got);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got event %0d with nothing expected", nm, got);
    end else begin
      e = exp_q.pop_front();
      if (e != got) begin
        errors++;
        $display("FAIL %s: got event %0d expected %0d", nm, got, e);
      end
    end
  endtask

  // Monitor: event codes 1..15 are ejects, 16 is done, 17 is fail.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eject_valid && eject_ready) pop_check("eject", int'(eject_code));
      if (done) pop_check("done", EV_DONE);
      if (fail) pop_check("fail", EV_FAIL);
    end
  end

  task automatic expect_eject(input int code);
    exp_q.push_back(code);
    exp_inv[code] = exp_inv[code] - 1;
  endtask

  task automatic check_inv(input string tag);
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("%s_inv%0d", tag, c), int'(dut.u_inv.inv_q[c]), exp_inv[c]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_eject_valid", int'(eject_valid), 0);
    exp_q.delete();
    for (int c = 0; c < 16; c++) exp_inv[c] = (c == 0) ? 0 : 100;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_ready", int'(req_ready), 1);
  endtask

  task automatic load(input int code, input int count);
    @(posedge clk);
    #1;
    load_valid = 1'b1;
    load_code  = 4'(code);
    load_count = CNT_W'(count);
    @(negedge clk);
    check("ready_during_load", int'(req_ready), 0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    if (code >= 1 && code <= 15) exp_inv[code] = count;
  endtask

  task automatic issue(input int amount);
    int n;
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_amount = AMT_W'(amount);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready %0d required 1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy %0d pending %0d required 0 0", tag, busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_eject_valid(input string tag);
    int n;
    n = 0;
    while (!eject_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_eject_valid"}, int'(eject_valid), 1);
  endtask

  initial begin
    int n;
    int saw_ev;
    req_valid   = 1'b0;
    req_amount  = '0;
    eject_ready = 1'b1;
    load_valid  = 1'b0;
    load_code   = '0;
    load_count  = '0;

    // 880 = 500+200+100+50+25+5
    do_reset();
    expect_eject(7); expect_eject(8); expect_eject(9);
    expect_eject(10); expect_eject(11); expect_eject(13);
    exp_q.push_back(EV_DONE);
    issue(880);
    wait_idle("t880");
    check_inv("t880");

    // zero amount: PLAN, EJECT, DONE
    exp_q.push_back(EV_DONE);
    issue(0);
    n = 0;
    saw_ev = 0;
    do begin
      @(negedge clk);
      n++;
      if (eject_valid) saw_ev = 1;
    end while (!done && n < 10);
    check("zero_done_latency", n, 3);
    check("zero_no_eject", saw_ev, 0);
    wait_idle("zero");

    // small coins emptied, code 0 load ignored, 3 cannot be met
    load(12, 0); load(13, 0); load(14, 0); load(15, 0);
    load(0, 5);
    exp_q.push_back(EV_FAIL);
    issue(3);
    wait_idle("fail3");
    check_inv("fail3");

    // single 200 left, load while busy is ignored
    do_reset();
    load(8, 1);
    expect_eject(8); expect_eject(9); expect_eject(9);
    exp_q.push_back(EV_DONE);
    issue(400);
    load_valid = 1'b1;
    load_code  = 4'd9;
    load_count = 8'd7;
    repeat (2) @(posedge clk);
    #1;
    load_valid = 1'b0;
    wait_idle("t400");
    check_inv("t400");

    // back-pressure holds code 7
    eject_ready = 1'b0;
    expect_eject(7);
    exp_q.push_back(EV_DONE);
    issue(500);
    wait_eject_valid("t500");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold_valid_%0d", k), int'(eject_valid), 1);
      check($sformatf("hold_code_%0d", k), int'(eject_code), 7);
    end
    @(posedge clk);
    #1;
    eject_ready = 1'b1;
    wait_idle("t500");
    check_inv("t500");

    // reset mid-EJECT
    eject_ready = 1'b0;
    issue(880);
    wait_eject_valid("mid");
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_eject_valid", int'(eject_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_fail", int'(fail), 0);
    check("mid_rst_ready", int'(req_ready), 0);
    exp_q.delete();
    for (int c = 0; c < 16; c++) exp_inv[c] = (c == 0) ? 0 : 100;
    check_inv("mid_rst");
    eject_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_release_ready", int'(req_ready), 1);
    check("mid_release_busy", int'(busy), 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events: pending %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached without finishing", $time);
    $fatal(1, "watchdog");
  end

endmodule
